// File: rtl/bus_pkg.sv
// Shared encodings for the byte-serial bus responder: phases, FSM states
// and the operation code latched from the read/write request lines.
package bus_pkg;

    // Which byte of a transfer the next request carries.
    typedef enum logic [1:0] {
        ADDR_LO = 2'd0,
        ADDR_HI = 2'd1,
        DATA    = 2'd2
    } phase_t;

    // Responder FSM states.
    typedef enum logic [1:0] {
        WAIT_REQ = 2'd0,
        MEM      = 2'd1,
        LEAD     = 2'd2,
        ACK      = 2'd3
    } state_t;

    // Operation code, bit order {read, write}.
    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_WRITE = 2'b01,
        OP_READ  = 2'b10,
        OP_BOTH  = 2'b11
    } op_t;

    // Phase sequence ADDR_LO -> ADDR_HI -> DATA -> ADDR_LO.
    function automatic phase_t next_phase(input phase_t p);
        case (p)
            ADDR_LO: next_phase = ADDR_HI;
            ADDR_HI: next_phase = DATA;
            default: next_phase = ADDR_LO;
        endcase
    endfunction

    // Exactly one of read/write is a well-formed request.
    function automatic logic op_is_valid(input op_t op);
        op_is_valid = (op == OP_WRITE) || (op == OP_READ);
    endfunction

endpackage

// File: rtl/bus_sync.sv
// Multi-flop synchroniser for one asynchronous bus control line.
module bus_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_reg;
    logic [STAGES-1:0] chain_next;

    // Each stage takes the value of the previous one; stage 0 samples the pin.
    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign chain_next[gi] = d;
            end else begin : g_rest
                assign chain_next[gi] = chain_reg[gi-1];
            end
        end
    endgenerate

    // Shift register, cleared by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_reg <= '0;
        end else begin
            chain_reg <= chain_next;
        end
    end

    assign q = chain_reg[STAGES-1];

endmodule

// File: rtl/mem_bus_responder.sv
// Target end of the byte-serial 4-phase bus. Collects addr-lo, addr-hi and a
// data byte per transfer, acknowledges each byte and turns the transfer into
// one valid/ready backend access, driving read data back onto the bus.
module mem_bus_responder
    import bus_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DRIVE_LEAD  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_req,
    input  logic        bus_read,
    input  logic        bus_write,
    input  logic [7:0]  bus_d_in,
    output logic [7:0]  bus_d_out,
    output logic        bus_d_oe,
    output logic        bus_ack,
    output logic        mem_valid,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic        mem_ready,
    input  logic [7:0]  mem_rdata,
    output logic        proto_err
);

    localparam int LEAD_W = (DRIVE_LEAD > 1) ? $clog2(DRIVE_LEAD) : 1;
    localparam logic [LEAD_W-1:0] LEAD_LAST = LEAD_W'(DRIVE_LEAD - 1);

    // Synchronised control lines, index 2 = req, 1 = read, 0 = write.
    logic [2:0] async_in;
    logic [2:0] sync_out;
    logic       req_s;
    logic       read_s;
    logic       write_s;

    assign async_in = {bus_req, bus_read, bus_write};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            bus_sync #(
                .STAGES (SYNC_STAGES)
            ) u_sync (
                .clk (clk),
                .rst (rst),
                .d   (async_in[gi]),
                .q   (sync_out[gi])
            );
        end
    endgenerate

    assign req_s   = sync_out[2];
    assign read_s  = sync_out[1];
    assign write_s = sync_out[0];

    state_t            state_reg,    state_next;
    phase_t            phase_reg,    phase_next;
    op_t               op_reg,       op_next;
    logic [15:0]       addr_reg,     addr_next;
    logic [7:0]        wdata_reg,    wdata_next;
    logic [7:0]        dout_reg,     dout_next;
    logic              oe_reg,       oe_next;
    logic              ack_reg,      ack_next;
    logic              err_reg,      err_next;
    logic [LEAD_W-1:0] lead_cnt_reg, lead_cnt_next;

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= WAIT_REQ;
            phase_reg    <= ADDR_LO;
            op_reg       <= OP_NONE;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            dout_reg     <= '0;
            oe_reg       <= 1'b0;
            ack_reg      <= 1'b0;
            err_reg      <= 1'b0;
            lead_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            phase_reg    <= phase_next;
            op_reg       <= op_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            dout_reg     <= dout_next;
            oe_reg       <= oe_next;
            ack_reg      <= ack_next;
            err_reg      <= err_next;
            lead_cnt_reg <= lead_cnt_next;
        end
    end

    // Next-state and datapath updates for the per-byte handshake.
    always_comb begin
        state_next    = state_reg;
        phase_next    = phase_reg;
        op_next       = op_reg;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        dout_next     = dout_reg;
        oe_next       = oe_reg;
        ack_next      = ack_reg;
        err_next      = 1'b0;
        lead_cnt_next = lead_cnt_reg;

        case (state_reg)
            WAIT_REQ: begin
                // Initiator dropped both request lines mid-transfer: restart.
                // A transfer latched as "neither" is malformed rather than
                // aborted, so it still runs through all three phases.
                if (phase_reg != ADDR_LO && op_reg != OP_NONE && !read_s && !write_s) begin
                    phase_next = ADDR_LO;
                end else if (req_s && !ack_reg) begin
                    case (phase_reg)
                        ADDR_LO: begin
                            addr_next[7:0] = bus_d_in;
                            op_next        = op_t'({read_s, write_s});
                            err_next       = !op_is_valid(op_t'({read_s, write_s}));
                            ack_next       = 1'b1;
                            state_next     = ACK;
                        end
                        ADDR_HI: begin
                            addr_next[15:8] = bus_d_in;
                            ack_next        = 1'b1;
                            state_next      = ACK;
                        end
                        default: begin
                            if (!op_is_valid(op_reg)) begin
                                // Malformed transfer: acknowledge, no access.
                                ack_next   = 1'b1;
                                state_next = ACK;
                            end else begin
                                if (op_reg == OP_WRITE) begin
                                    wdata_next = bus_d_in;
                                end
                                state_next = MEM;
                            end
                        end
                    endcase
                end
            end

            MEM: begin
                // Address and write data stay put until the backend accepts.
                if (mem_ready) begin
                    if (op_reg == OP_WRITE) begin
                        ack_next   = 1'b1;
                        state_next = ACK;
                    end else begin
                        dout_next     = mem_rdata;
                        oe_next       = 1'b1;
                        lead_cnt_next = '0;
                        state_next    = LEAD;
                    end
                end
            end

            LEAD: begin
                // Read data is driven for DRIVE_LEAD cycles before ack rises.
                if (lead_cnt_reg == LEAD_LAST) begin
                    ack_next   = 1'b1;
                    state_next = ACK;
                end else begin
                    lead_cnt_next = lead_cnt_reg + LEAD_W'(1);
                end
            end

            default: begin
                // ACK: release the bus together with ack once req is gone.
                if (!req_s) begin
                    ack_next   = 1'b0;
                    oe_next    = 1'b0;
                    phase_next = next_phase(phase_reg);
                    state_next = WAIT_REQ;
                end
            end
        endcase
    end

    assign bus_ack   = ack_reg;
    assign bus_d_oe  = oe_reg;
    assign bus_d_out = dout_reg;
    assign mem_valid = (state_reg == MEM);
    assign mem_we    = (state_reg == MEM) && (op_reg == OP_WRITE);
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign proto_err = err_reg;

endmodule
